// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline: width math, popcount and perf counter width.
// Consumed by pipe_elastic (optional counters enabled with PIPE_ELASTIC_PERF_EN).
package pipe_pkg;

  localparam int PERF_CNT_W = 32;
  // Widest slot vector popcount() accepts; callers zero-extend into it.
  localparam int POP_MAX_W  = 64;

  // Bits needed to represent the values 0..n inclusive.
  function automatic int clog2_plus1(input int n);
    int r;
    r = 0;
    while ((1 << r) < (n + 1)) r++;
    return r;
  endfunction

  function automatic int popcount(input logic [POP_MAX_W-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX_W; i++) cnt += int'(vec[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus payload that either loads from its source
// when the chain advances, or holds (and can be squashed) when it stalls.
module pipe_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             kill_src,
  input  logic             kill_self,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (adv) begin
      valid <= src_valid & ~kill_src;
      // Payload only follows a live source so idle slots keep their last value.
      if (src_valid) data <= src_data;
    end else if (kill_self) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_elastic.sv
// DEPTH-slot elastic pipeline with bubble collapsing and partial (youngest-K) flush.
// Define PIPE_ELASTIC_PERF_EN to add saturating stall_cnt / bubble_cnt outputs.
module pipe_elastic
  import pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = clog2_plus1(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   flush,
  input  logic [CW-1:0]          flush_upto,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [CW-1:0]          occupancy
`ifdef PIPE_ELASTIC_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]  stall_cnt,
  output logic [PERF_CNT_W-1:0]  bubble_cnt
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and in_ready depends only on slot state and
  // out_ready (never on in_valid or flush).

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] kill_vec;
  logic [CW-1:0]    k_eff;
  logic             full_above;

  assign k_eff = (flush_upto > CW'(DEPTH)) ? CW'(DEPTH) : flush_upto;

  // Slot i moves iff some slot at or above it is empty or the consumer takes the
  // oldest item; written in closed form so adv has no bit-to-bit feedback.
  always_comb begin
    adv        = '0;
    full_above = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      full_above = 1'b1;
      for (int j = i; j < DEPTH; j++) full_above = full_above & v[j];
      adv[i] = out_ready | ~full_above;
    end
  end

  assign in_ready = adv[0];

  // A flush of K kills whatever would occupy slots 0..K-1 after this edge, so the
  // input is dropped for any K>=1 and K=0 leaves the pipe untouched.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign kill_vec[i] = flush && (k_eff > CW'(i));

    if (i == 0) begin : g_head
      pipe_slot #(.WIDTH(WIDTH)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .adv       (adv[i]),
        .src_valid (in_valid),
        .src_data  (in_data),
        .kill_src  (kill_vec[i]),
        .kill_self (kill_vec[i]),
        .valid     (v[i]),
        .data      (d[i])
      );
    end else begin : g_body
      pipe_slot #(.WIDTH(WIDTH)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .adv       (adv[i]),
        .src_valid (v[i-1]),
        .src_data  (d[i-1]),
        .kill_src  (kill_vec[i]),
        .kill_self (kill_vec[i]),
        .valid     (v[i]),
        .data      (d[i])
      );
    end

    assign stage_data[i*WIDTH +: WIDTH] = d[i];
  end

  // A full-depth flush also covers the oldest slot, so it must not hand it out.
  assign out_valid   = v[DEPTH-1] & ~(flush & (k_eff == CW'(DEPTH)));
  assign out_data    = d[DEPTH-1];
  assign stage_valid = v;
  assign occupancy   = CW'(popcount(POP_MAX_W'(v)));

`ifdef PIPE_ELASTIC_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && (occupancy != '0) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule
